stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control FSM and time-of-count datapath for the stopwatch. Consumes the square-wave outputs of the clock divider (1 Hz, 2 Hz, fast ~250 Hz, blink ~4 Hz) plus the board buttons and switches. Sequences run, pause, clear and field adjust, and produces four BCD digits with a per-digit blank mask for the seven-segment driver. All logic is in the 100 MHz `clk` domain; divider outputs are treated as same-domain levels and edge-detected.

Parameters:
DEB_SAMPLES, 3, consecutive equal button samples (taken on fast-tick edges) required to change a debounced level
MAX_MIN, 59, highest minutes value before wrap

Ports:
clk  in  1  100 MHz system clock
rst  in  1  asynchronous, active-high reset
div_1hz  in  1  divider 1 Hz square wave (level)
div_2hz  in  1  divider 2 Hz square wave (level)
div_fast  in  1  divider fast square wave, debounce sample strobe source
div_blink  in  1  divider blink square wave
btn_pause  in  1  raw pause/resume button, asynchronous
btn_clear  in  1  raw clear button, asynchronous
sw_adj  in  1  adjust-mode switch, asynchronous level
sw_sel  in  1  adjust field select: 0 = minutes, 1 = seconds
min_tens  out  4  BCD minutes tens (0–5)
min_ones  out  4  BCD minutes ones (0–9)
sec_tens  out  4  BCD seconds tens (0–5)
sec_ones  out  4  BCD seconds ones (0–9)
blank  out  4  per-digit blank, bit3 = min_tens … bit0 = sec_ones
state_o  out  2  current FSM state code

Behaviour:
- Reset is asynchronous. All digits = 0, blank = 0, state = PAUSED, edge-detect history = 0, debounce counters and levels = 0, armed = 0.
- armed is set on the first clk after reset deasserts. No tick edge or button press is reported while armed = 0, which suppresses spurious edges at reset release.
- Tick edges are single-cycle pulses: edge_x = div_x & ~prev_x & armed, with prev_x registered every cycle.
- Buttons and switches pass through a 2-flop synchronizer.
- Debounce: on each fast-tick edge, sample the synchronized button. If the sample differs from the debounced level, increment a counter; otherwise clear it. When the counter reaches DEB_SAMPLES, flip the level and clear the counter. A press is a single-cycle pulse on the debounced 0→1 transition.
- State codes: PAUSED = 0, RUN = 1, ADJ_FROM_PAUSED = 2, ADJ_FROM_RUN = 3.
- Transitions:
  - PAUSED + pause press → RUN
  - RUN + pause press → PAUSED
  - PAUSED or RUN with sync sw_adj = 1 → the matching ADJ_* state
  - ADJ_* with sync sw_adj = 0 → the originating state
  - Pause presses are ignored in ADJ_* states.
- Counting: in RUN, each 1 Hz edge increments mm:ss in BCD.
  - sec_ones 9→0 carries to sec_tens; sec_tens 5→0 carries to minutes.
  - 59:59 → 00:00 (MAX_MIN wrap), with no overflow flag.
- Adjust:
  - In ADJ_* states the 1 Hz edge is ignored.
  - Each 2 Hz edge increments only the field selected by sync sw_sel, modulo 60 with BCD digits, and never carries into the other field.
  - The selected field's two blank bits equal ~div_blink; all other blank bits are 0.
  - blank is 0 in PAUSED and RUN.
- Clear press, in any state: digits → 00:00 and state unchanged.
- Simultaneous events:
  - Clear wins over any increment in the same cycle.
  - A pause press coincident with a 1 Hz edge in RUN still counts that edge; the count uses the pre-transition state.
  - A 2 Hz edge in the same cycle the state enters ADJ_* is not applied.
- Latency: a digit or state change is visible one clk after the cycle in which the edge or press pulse is high. Counts change 1 clk after the div_* rising edge reaches the port.
- Reset mid-adjust or mid-debounce aborts immediately to the reset values above.

Decomposition:
- Package stopwatch_pkg holds:
  - state codes PAUSED/RUN/ADJ_FROM_PAUSED/ADJ_FROM_RUN
  - BCD digit width 4
  - field-select encodings
- One sub-module `btn_debounce` (synchronizer + sampler + press pulse), instantiated twice.
- Edge detection, FSM and BCD counter remain in stopwatch_ctrl.

Test Plan:
1. Reset, pause press (held 5 fast edges), then 75 div_1hz rising edges → state_o = 1, digits 01:15, blank = 0.
2. Bounce btn_pause 1-0-1 across 3 fast edges, then hold → exactly one press; RUN↔PAUSED toggles exactly once.
3. Preload 59:58 in RUN, 3 div_1hz edges → 59:59, 00:00, 00:01.
4. From RUN at 00:10, sw_adj = 1, sw_sel = 1, 55 div_2hz edges → digits 00:05 (seconds wrap, minutes unchanged); blank = 0011 while div_blink = 0 and 0000 while it is 1; 1 Hz edges ignored; sw_adj = 0 → state_o = 1.
5. In RUN at 00:42, clear press debounced on the same cycle as a 1 Hz edge → 00:00 and state_o = 1.
6. Assert rst while ADJ_FROM_RUN at 12:34 → all digits = 0, blank = 0, state_o = 0 asynchronously. Release rst with div_1hz high → no increment on the first cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch control path.
package stopwatch_pkg;

  localparam int DIGIT_W   = 4;
  // Both fields are adjusted modulo 60 regardless of the run-time minute wrap.
  localparam int FIELD_MAX = 59;

  typedef enum logic [1:0] {
    PAUSED          = 2'd0,
    RUN             = 2'd1,
    ADJ_FROM_PAUSED = 2'd2,
    ADJ_FROM_RUN    = 2'd3
  } sw_state_e;

  // Adjust field select, as seen on sw_sel.
  localparam logic FSEL_MIN = 1'b0;
  localparam logic FSEL_SEC = 1'b1;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd2_t;

  // True when the two-digit BCD value has reached its wrap point.
  function automatic logic bcd2_at_max(input bcd2_t v, input int max_val);
    return (int'(v.tens) * 10 + int'(v.ones)) >= max_val;
  endfunction

  // Two-digit BCD increment, wrapping to 00 after max_val.
  function automatic bcd2_t bcd2_inc(input bcd2_t v, input int max_val);
    bcd2_t r;
    r = v;
    if (bcd2_at_max(v, max_val)) begin
      r = '0;
    end else if (v.ones == DIGIT_W'(9)) begin
      r.tens = v.tens + DIGIT_W'(1);
      r.ones = '0;
    end else begin
      r.ones = v.ones + DIGIT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Button conditioner: 2-flop synchronizer, strobe-sampled debounce, press pulse.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_async,
  input  logic sample_stb,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_SAMPLES + 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             level;
  logic             differ;
  logic             flip;

  assign differ = sync[1] != level;
  // The level flips on the sample that brings the run of differing samples to DEB_SAMPLES.
  assign flip   = sample_stb & differ & (cnt == CNT_W'(DEB_SAMPLES - 1));
  assign press  = flip & ~level;

  // Two-flop synchronizer for the raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], btn_async};
  end

  // Count consecutive differing samples; flip the debounced level when enough accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sample_stb) begin
      if (flip) begin
        level <= ~level;
        cnt   <= '0;
      end else if (differ) begin
        cnt   <= cnt + CNT_W'(1);
      end else begin
        cnt   <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: tick edge detect, run/pause/adjust FSM, mm:ss BCD counter, blink mask.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_SAMPLES = 3,
  parameter int MAX_MIN     = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       div_1hz,
  input  logic       div_2hz,
  input  logic       div_fast,
  input  logic       div_blink,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] blank,
  output logic [1:0] state_o
);

  localparam int NUM_BTN   = 2;
  localparam int BTN_PAUSE = 0;
  localparam int BTN_CLEAR = 1;

  logic               armed;
  logic               prev_1hz, prev_2hz, prev_fast;
  logic               edge_1hz, edge_2hz, edge_fast;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;
  logic [1:0]         adj_sync, sel_sync;
  logic               adj_s, sel_s;
  logic               in_adj;
  sw_state_e          state, state_nxt;
  bcd2_t              mins, secs;

  // Edges are gated by armed so levels already high at reset release are not seen as edges.
  assign edge_1hz  = div_1hz  & ~prev_1hz  & armed;
  assign edge_2hz  = div_2hz  & ~prev_2hz  & armed;
  assign edge_fast = div_fast & ~prev_fast & armed;

  // Arm one cycle after reset and keep divider history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed     <= 1'b0;
      prev_1hz  <= 1'b0;
      prev_2hz  <= 1'b0;
      prev_fast <= 1'b0;
    end else begin
      armed     <= 1'b1;
      prev_1hz  <= div_1hz;
      prev_2hz  <= div_2hz;
      prev_fast <= div_fast;
    end
  end

  assign btn_raw = {btn_clear, btn_pause};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
      .clk        (clk),
      .rst        (rst),
      .btn_async  (btn_raw[b]),
      .sample_stb (edge_fast),
      .press      (press[b])
    );
  end

  // Switches only need synchronizing; they are levels, not presses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adj_sync <= '0;
      sel_sync <= '0;
    end else begin
      adj_sync <= {adj_sync[0], sw_adj};
      sel_sync <= {sel_sync[0], sw_sel};
    end
  end

  assign adj_s  = adj_sync[1];
  assign sel_s  = sel_sync[1];
  assign in_adj = (state == ADJ_FROM_PAUSED) || (state == ADJ_FROM_RUN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PAUSED;
    else     state <= state_nxt;
  end

  // Next state: adjust switch has priority over a pause press; pauses are ignored while adjusting.
  always_comb begin
    state_nxt = state;
    unique case (state)
      PAUSED: begin
        if (adj_s)                 state_nxt = ADJ_FROM_PAUSED;
        else if (press[BTN_PAUSE]) state_nxt = RUN;
      end
      RUN: begin
        if (adj_s)                 state_nxt = ADJ_FROM_RUN;
        else if (press[BTN_PAUSE]) state_nxt = PAUSED;
      end
      ADJ_FROM_PAUSED: if (!adj_s) state_nxt = PAUSED;
      ADJ_FROM_RUN:    if (!adj_s) state_nxt = RUN;
      default:         state_nxt = PAUSED;
    endcase
  end

  // Time-of-count: clear beats any increment; decisions use the pre-transition state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mins <= '0;
      secs <= '0;
    end else if (press[BTN_CLEAR]) begin
      mins <= '0;
      secs <= '0;
    end else if (state == RUN && edge_1hz) begin
      secs <= bcd2_inc(secs, FIELD_MAX);
      if (bcd2_at_max(secs, FIELD_MAX)) mins <= bcd2_inc(mins, MAX_MIN);
    end else if (in_adj && edge_2hz) begin
      if (sel_s == FSEL_SEC) secs <= bcd2_inc(secs, FIELD_MAX);
      else                   mins <= bcd2_inc(mins, FIELD_MAX);
    end
  end

  // Blink the field being adjusted; everything is lit otherwise.
  always_comb begin
    blank = '0;
    if (in_adj) begin
      if (sel_s == FSEL_SEC) blank[1:0] = {2{~div_blink}};
      else                   blank[3:2] = {2{~div_blink}};
    end
  end

  assign min_tens = mins.tens;
  assign min_ones = mins.ones;
  assign sec_tens = secs.tens;
  assign sec_ones = secs.ones;
  assign state_o  = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       div_1hz, div_2hz, div_fast, div_blink;
  logic       btn_pause, btn_clear, sw_adj, sw_sel;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
  logic [1:0] state_o;

  int tests  = 0;
  int failed = 0;

  stopwatch_ctrl #(.DEB_SAMPLES(3), .MAX_MIN(59)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_1hz   (div_1hz),
    .div_2hz   (div_2hz),
    .div_fast  (div_fast),
    .div_blink (div_blink),
    .btn_pause (btn_pause),
    .btn_clear (btn_clear),
    .sw_adj    (sw_adj),
    .sw_sel    (sw_sel),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .blank     (blank),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic fast_pulse();
    div_fast = 1'b1; step();
    div_fast = 1'b0; step();
  endtask

  task automatic hz1_pulse();
    div_1hz = 1'b1; step();
    div_1hz = 1'b0; step();
  endtask

  task automatic hz2_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      div_2hz = 1'b1; step();
      div_2hz = 1'b0; step();
    end
  endtask

  task automatic hz1_pulses(input int n);
    for (int i = 0; i < n; i++) hz1_pulse();
  endtask

  task automatic set_btn(input int which, input logic v);
    if (which == 0) btn_pause = v;
    else            btn_clear = v;
  endtask

  // Clean press held for 5 fast edges, then released for 5. The 3rd held edge is
  // where the debounced level flips; with_1hz makes a 1 Hz edge land on that cycle.
  task automatic press_btn(input int which, input logic with_1hz);
    set_btn(which, 1'b1);
    steps(3);
    fast_pulse();
    fast_pulse();
    div_fast = 1'b1;
    div_1hz  = with_1hz;
    step();
    div_fast = 1'b0;
    div_1hz  = 1'b0;
    step();
    fast_pulse();
    fast_pulse();
    set_btn(which, 1'b0);
    steps(3);
    for (int i = 0; i < 5; i++) fast_pulse();
  endtask

  initial begin
    rst = 1'b1;
    div_1hz = 0; div_2hz = 0; div_fast = 0; div_blink = 0;
    btn_pause = 0; btn_clear = 0; sw_adj = 0; sw_sel = 0;
    steps(2);
    chk("reset_digits", digits(), 16'h0000);
    chk("reset_blank",  {12'h0, blank}, 16'h0000);
    chk("reset_state",  {14'h0, state_o}, 16'h0000);
    rst = 1'b0;
    step();

    // 1: start running, count 75 seconds.
    press_btn(0, 1'b0);
    chk("t1_state_run", {14'h0, state_o}, 16'h0001);
    hz1_pulses(75);
    chk("t1_digits", digits(), 16'h0115);
    chk("t1_blank",  {12'h0, blank}, 16'h0000);

    // 2: bounce 1-0-1 across three fast edges, then hold: one toggle only.
    btn_pause = 1'b1; steps(3); fast_pulse();
    btn_pause = 1'b0; steps(3); fast_pulse();
    chk("t2_bounce_no_toggle", {14'h0, state_o}, 16'h0001);
    btn_pause = 1'b1; steps(3);
    for (int i = 0; i < 5; i++) fast_pulse();
    btn_pause = 1'b0; steps(3);
    for (int i = 0; i < 5; i++) fast_pulse();
    chk("t2_single_toggle", {14'h0, state_o}, 16'h0000);
    chk("t2_digits_held", digits(), 16'h0115);

    // 3: preload 59:58 through adjust from PAUSED, then run across the wrap.
    sw_adj = 1'b1; sw_sel = 1'b0; steps(3);
    chk("t3_state_adjp", {14'h0, state_o}, 16'h0002);
    div_blink = 1'b0; #1;
    chk("t3_blank_min", {12'h0, blank}, 16'h000c);
    hz2_pulses(58);
    chk("t3_min_only", digits(), 16'h5915);
    sw_sel = 1'b1; steps(3);
    hz2_pulses(43);
    chk("t3_preload", digits(), 16'h5958);
    sw_adj = 1'b0; steps(3);
    chk("t3_back_paused", {14'h0, state_o}, 16'h0000);
    press_btn(0, 1'b0);
    chk("t3_run", {14'h0, state_o}, 16'h0001);
    hz1_pulse(); chk("t3_5959", digits(), 16'h5959);
    hz1_pulse(); chk("t3_wrap", digits(), 16'h0000);
    hz1_pulse(); chk("t3_0001", digits(), 16'h0001);
    hz1_pulses(9);
    chk("t4_start", digits(), 16'h0010);

    // 4: adjust seconds from RUN; a 2 Hz edge on the entry cycle is dropped.
    sw_adj = 1'b1; sw_sel = 1'b1;
    steps(2);
    div_2hz = 1'b1; step();
    chk("t4_entry_2hz_dropped", digits(), 16'h0010);
    chk("t4_state_adjr", {14'h0, state_o}, 16'h0003);
    div_2hz = 1'b0; step();
    hz2_pulses(55);
    chk("t4_sec_wrap", digits(), 16'h0005);
    div_blink = 1'b0; #1;
    chk("t4_blank_on", {12'h0, blank}, 16'h0003);
    div_blink = 1'b1; #1;
    chk("t4_blank_off", {12'h0, blank}, 16'h0000);
    hz1_pulses(2);
    chk("t4_1hz_ignored", digits(), 16'h0005);
    sw_adj = 1'b0; steps(3);
    chk("t4_back_run", {14'h0, state_o}, 16'h0001);
    chk("t4_run_blank", {12'h0, blank}, 16'h0000);

    // 5: clear coincident with a 1 Hz edge at 00:42.
    hz1_pulses(37);
    chk("t5_start", digits(), 16'h0042);
    press_btn(1, 1'b1);
    chk("t5_clear_wins", digits(), 16'h0000);
    chk("t5_state_kept", {14'h0, state_o}, 16'h0001);

    // Pause coincident with a 1 Hz edge still counts it.
    press_btn(0, 1'b1);
    chk("pause_1hz_count", digits(), 16'h0001);
    chk("pause_1hz_state", {14'h0, state_o}, 16'h0000);

    // 6: reach 12:34 in ADJ_FROM_RUN, then reset asynchronously.
    press_btn(0, 1'b0);
    sw_adj = 1'b1; sw_sel = 1'b0; steps(3);
    chk("t6_state_adjr", {14'h0, state_o}, 16'h0003);
    hz2_pulses(12);
    sw_sel = 1'b1; steps(3);
    hz2_pulses(33);
    chk("t6_1234", digits(), 16'h1234);
    div_blink = 1'b0;
    sw_adj = 1'b0;
    div_1hz = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("t6_async_digits", digits(), 16'h0000);
    chk("t6_async_blank", {12'h0, blank}, 16'h0000);
    chk("t6_async_state", {14'h0, state_o}, 16'h0000);
    steps(2);
    rst = 1'b0;
    step();
    chk("t6_release_1", digits(), 16'h0000);
    step();
    chk("t6_release_2", digits(), 16'h0000);
    // Run with div_1hz still high: no stale edge, then one clean edge counts once.
    press_btn(0, 1'b1);
    chk("t6_run_after_reset", {14'h0, state_o}, 16'h0001);
    chk("t6_no_stale_edge", digits(), 16'h0000);
    hz1_pulse();
    chk("t6_one_edge", digits(), 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
